// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode, ID/EX control register and hazard control (load-use, jump/branch flush, illegal opcode).
// Optional sticky illegal-opcode trap enabled by defining CU_ILLEGAL_TRAP_EN.
module pipe_ctrl_unit #(
  parameter int unsigned I_SIZE   = 32,
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned BR_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [I_SIZE-1:0] id_instruction,
  input  logic              ex_branch_taken,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_mem_write,
  output logic              ex_memread,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [1:0]        ex_aluop,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              id_stall,
  output logic              if_flush,
  output logic              illegal
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned LOW_W = I_SIZE - OPC_W - 3 * REG_W;
  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_JUMP = OPC_W'(4);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic             load_bubble;

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             unused_low;

  assign opcode     = id_instruction[I_SIZE-1 -: OPC_W];
  assign id_rs      = id_instruction[I_SIZE-OPC_W-1 -: REG_W];
  assign id_rt      = id_instruction[I_SIZE-OPC_W-REG_W-1 -: REG_W];
  assign id_rd      = id_instruction[I_SIZE-OPC_W-2*REG_W-1 -: REG_W];
  assign unused_low = ^id_instruction[LOW_W-1:0];

  logic       dec_regwrite, dec_memtoreg, dec_mem_write, dec_memread;
  logic       dec_alusrc, dec_regdst, dec_branch, dec_jump;
  logic [1:0] dec_aluop;
  logic       dec_illegal, rt_use, load_use;

  // Opcode decode into the control bundle
  always_comb begin
    dec_regwrite  = 1'b0;
    dec_memtoreg  = 1'b0;
    dec_mem_write = 1'b0;
    dec_memread   = 1'b0;
    dec_alusrc    = 1'b0;
    dec_regdst    = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_aluop     = 2'b00;
    dec_illegal   = 1'b0;
    rt_use        = 1'b0;
    case (opcode)
      OP_R:    begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluop = 2'b10; rt_use = 1'b1; end
      OP_LW:   begin dec_memread = 1'b1; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_memtoreg = 1'b1; end
      OP_SW:   begin dec_mem_write = 1'b1; dec_alusrc = 1'b1; rt_use = 1'b1; end
      OP_BEQ:  begin dec_branch = 1'b1; dec_aluop = 2'b01; rt_use = 1'b1; end
      OP_JUMP: begin dec_jump = 1'b1; dec_aluop = 2'b11; end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (rt_use && (ex_rt == id_rt)));

  // Branch flush FSM and hazard outputs; flush beats stall, trap freezes everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trap_d      = trap_q;
    id_stall    = 1'b0;
    if_flush    = 1'b0;
    illegal     = 1'b0;
    load_bubble = 1'b0;
    if (rst) begin
      load_bubble = 1'b1;
    end else if (trap_q) begin
      illegal     = 1'b1;
      id_stall    = 1'b1;
      load_bubble = 1'b1;
    end else begin
      illegal = dec_illegal;
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            if_flush    = 1'b1;
            load_bubble = 1'b1;
            if (BR_FLUSH > 1) begin
              state_d = FLUSH;
              cnt_d   = CNT_W'(BR_FLUSH - 1);
            end
          end
        end
        FLUSH: begin
          if_flush    = 1'b1;
          load_bubble = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
      if (!if_flush) begin
        if (load_use) begin
          id_stall    = 1'b1;
          load_bubble = 1'b1;
        end else begin
          if_flush    = dec_jump;
          load_bubble = dec_illegal;
`ifdef CU_ILLEGAL_TRAP_EN
          trap_d      = dec_illegal;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  // ID/EX control register
  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      ex_regwrite  <= 1'b0;
      ex_memtoreg  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_memread   <= 1'b0;
      ex_alusrc    <= 1'b0;
      ex_regdst    <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_aluop     <= 2'b00;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
    end else begin
      ex_regwrite  <= dec_regwrite;
      ex_memtoreg  <= dec_memtoreg;
      ex_mem_write <= dec_mem_write;
      ex_memread   <= dec_memread;
      ex_alusrc    <= dec_alusrc;
      ex_regdst    <= dec_regdst;
      ex_branch    <= dec_branch;
      ex_jump      <= dec_jump;
      ex_aluop     <= dec_aluop;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
    end
  end

endmodule
